// File: rtl/prog_loader.sv
// prog_loader: streams a program into the CPU instruction memory, runs the
// CPU for a fixed number of cycles, then streams data memory back out.
// One load/run/dump sequence per start pulse, accepted from IDLE or DONE.
module prog_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       prog_len,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [7:0]       dump_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic [63:0]      imem_addr,
    output logic             imem_wen,
    output logic [31:0]      imem_wdata,
    output logic             cpu_enable,
    output logic [63:0]      dmem_addr,
    output logic             dmem_ren,
    input  logic [63:0]      dmem_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             busy,
    output logic             done
);

    // count widths hold 0..DEPTH; index widths hold 0..DEPTH-1
    localparam int PCW = $clog2(IMEM_WORDS + 1);
    localparam int DCW = $clog2(DMEM_WORDS + 1);
    localparam int KW  = $clog2(IMEM_WORDS);
    localparam int JW  = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DUMP = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    // captured, saturated sequence parameters
    logic [PCW-1:0]   prog_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [DCW-1:0]   dump_cnt;

    // progress counters
    logic [KW-1:0]    wr_idx;   // next instruction word index k
    logic [CNT_W-1:0] run_idx;  // RUN cycles elapsed
    logic [DCW-1:0]   rd_idx;   // reads issued (j of the next read)
    logic [DCW-1:0]   acc_idx;  // words accepted downstream

    // read pipeline: one read in flight plus a holding slot for data that
    // returns while the output register is stalled
    logic             rd_pend;
    logic             skid_vld;
    logic [63:0]      skid_data;

    logic [PCW-1:0]   prog_sat;
    logic [DCW-1:0]   dump_sat;
    logic             capture;
    logic             load_beat, load_last, run_last;
    logic             out_free, consume, rd_issue, dump_last;

    // clamp requested lengths to the memory depths
    always_comb begin
        prog_sat = (32'(prog_len) > IMEM_WORDS) ? PCW'(IMEM_WORDS) : PCW'(prog_len);
        dump_sat = (32'(dump_len) > DMEM_WORDS) ? DCW'(DMEM_WORDS) : DCW'(dump_len);
    end

    // per-cycle events shared by the FSM and the datapath
    always_comb begin
        capture   = start && ((state == IDLE) || (state == DONE));
        load_beat = (state == LOAD) && s_valid;
        load_last = load_beat && (PCW'(wr_idx) == (prog_cnt - PCW'(1)));
        run_last  = (state == RUN) && (run_idx == (run_cnt - CNT_W'(1)));
        consume   = m_valid && m_ready;
        out_free  = !m_valid || m_ready;
        rd_issue  = (state == DUMP) && (rd_idx < dump_cnt) && out_free;
        dump_last = (state == DUMP) && consume && (acc_idx == (dump_cnt - DCW'(1)));
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state selection and memory/CPU port drive
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        imem_wen   = 1'b0;
        imem_wdata = 32'd0;
        imem_addr  = 64'd0;
        cpu_enable = 1'b0;
        dmem_ren   = 1'b0;
        dmem_addr  = 64'd0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    // skip any phase whose count is zero
                    if (prog_sat != '0)        state_nxt = LOAD;
                    else if (run_cycles != '0) state_nxt = RUN;
                    else if (dump_sat != '0)   state_nxt = DUMP;
                    else                       state_nxt = DONE;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                s_ready    = 1'b1;
                imem_addr  = 64'({wr_idx, 2'b00});
                imem_wen   = load_beat;
                imem_wdata = load_beat ? s_data : 32'd0;
                if (load_last) begin
                    if (run_cnt != '0)       state_nxt = RUN;
                    else if (dump_cnt != '0) state_nxt = DUMP;
                    else                     state_nxt = DONE;
                end
            end
            RUN: begin
                busy       = 1'b1;
                cpu_enable = 1'b1;
                if (run_last) state_nxt = (dump_cnt != '0) ? DUMP : DONE;
            end
            DUMP: begin
                busy      = 1'b1;
                dmem_ren  = rd_issue;
                dmem_addr = rd_issue ? 64'({rd_idx[JW-1:0], 3'b000}) : 64'd0;
                if (dump_last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // capture sequence parameters and advance the phase counters
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_cnt <= '0;
            run_cnt  <= '0;
            dump_cnt <= '0;
            wr_idx   <= '0;
            run_idx  <= '0;
            rd_idx   <= '0;
            acc_idx  <= '0;
        end else if (capture) begin
            prog_cnt <= prog_sat;
            run_cnt  <= run_cycles;
            dump_cnt <= dump_sat;
            wr_idx   <= '0;
            run_idx  <= '0;
            rd_idx   <= '0;
            acc_idx  <= '0;
        end else begin
            if (load_beat)      wr_idx  <= wr_idx + KW'(1);
            if (state == RUN)   run_idx <= run_idx + CNT_W'(1);
            if (rd_issue)       rd_idx  <= rd_idx + DCW'(1);
            if (consume)        acc_idx <= acc_idx + DCW'(1);
        end
    end

    // read-return path: data lands one cycle after the read; if the output
    // register is stalled at that moment it waits in the holding slot, which
    // always drains before the next return because no read is issued while
    // the output register is full and stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            skid_vld  <= 1'b0;
            skid_data <= 64'd0;
            m_valid   <= 1'b0;
            m_data    <= 64'd0;
        end else begin
            rd_pend <= rd_issue;
            if (out_free) begin
                if (skid_vld) begin
                    m_data   <= skid_data;
                    m_valid  <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (rd_pend) begin
                    m_data  <= dmem_rdata;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_data <= dmem_rdata;
                skid_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected instruction writes and dump
// words are queued when a sequence is launched and popped as the DUT emits them.
module tb_prog_loader;

    localparam int IW = 128;
    localparam int DW = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  prog_len = 8'd0;
    logic [31:0] run_cycles = 32'd0;
    logic [7:0]  dump_len = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic [63:0] imem_addr;
    logic        imem_wen;
    logic [31:0] imem_wdata;
    logic        cpu_enable;
    logic [63:0] dmem_addr;
    logic        dmem_ren;
    logic [63:0] dmem_rdata = 64'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic        busy;
    logic        done;

    prog_loader #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .dump_len(dump_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
        .cpu_enable(cpu_enable), .dmem_addr(dmem_addr), .dmem_ren(dmem_ren),
        .dmem_rdata(dmem_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // data memory model with registered read
    logic [63:0] dmem [DW];
    always @(posedge clk) if (dmem_ren) dmem_rdata <= dmem[dmem_addr[9:3]];

    // port strobes must be mutually exclusive every cycle
    always @(negedge clk) begin
        #2;
        n_chk++;
        if ((int'(imem_wen) + int'(cpu_enable) + int'(dmem_ren)) > 1) begin
            n_fail++;
            $display("FAIL exclusive_strobes: wen=%0b en=%0b ren=%0b expected at most one", imem_wen, cpu_enable, dmem_ren);
        end
    end

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         imem_q[$];
    logic [63:0] m_q[$];

    // per-sequence observations used by scenario tasks
    int          wen_cnt, en_cnt, first_wen, last_wen, first_en, last_en, first_ren;
    logic [63:0] last_waddr;

    task automatic run_sequence(input int plen, input int rcyc, input int dlen,
                                input bit bp, input bit poke, input int abort_after);
        int          ep, ed, cyc, acc, last_acc, done_cyc;
        bit          prev_stall, abort_now, in_rst, aborted, finished;
        logic [63:0] prev_data;
        logic [31:0] words[$];
        wr_t         w;
        ep = (plen > IW) ? IW : plen;
        ed = (dlen > DW) ? DW : dlen;
        imem_q.delete(); m_q.delete(); words.delete();
        for (int k = 0; k < ep; k++) begin
            w.addr = 64'(4 * k);
            w.data = $urandom;
            words.push_back(w.data);
            imem_q.push_back(w);
        end
        for (int j = 0; j < ed; j++) m_q.push_back(dmem[j]);
        wen_cnt = 0; en_cnt = 0; first_wen = -1; last_wen = -1;
        first_en = -1; last_en = -1; first_ren = -1; last_waddr = 64'd0;
        acc = 0; last_acc = -1; done_cyc = -1; cyc = 0;
        prev_stall = 0; prev_data = 64'd0; abort_now = 0; in_rst = 0; aborted = 0; finished = 0;

        @(negedge clk);
        start = 1'b1; rst = 1'b0;
        prog_len = plen[7:0]; run_cycles = 32'(rcyc); dump_len = dlen[7:0];
        s_valid = 1'b1; m_ready = 1'b1;

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0; rst = 1'b0;
            if (abort_now) begin rst = 1'b1; abort_now = 0; in_rst = 1; end
            s_data  = (wen_cnt < words.size()) ? words[wen_cnt] : 32'hDEAD_BEEF;
            m_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            if (poke && en_cnt == 1) begin
                start = 1'b1; prog_len = 8'd7; run_cycles = 32'd99; dump_len = 8'd9;
            end
            #1;
            if (aborted) begin
                n_chk++;
                if (m_valid !== 1'b0 || busy !== 1'b0 || dmem_ren !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_state: m_valid=%0b busy=%0b ren=%0b expected 0 0 0", m_valid, busy, dmem_ren);
                end
                finished = 1;
            end else if (in_rst) begin
                in_rst = 0; aborted = 1;
            end else begin
                if (cyc == 0 && (ep + rcyc + ed) > 0) begin
                    n_chk++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL start_accept: busy=%0b done=%0b expected 1 0", busy, done);
                    end
                end
                if (imem_wen) begin
                    n_chk++;
                    if (imem_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL imem_extra: write addr=%0h with none expected", imem_addr);
                    end else begin
                        w = imem_q.pop_front();
                        if (imem_addr !== w.addr || imem_wdata !== w.data) begin
                            n_fail++;
                            $display("FAIL imem_write: addr=%0h data=%08h expected addr=%0h data=%08h",
                                     imem_addr, imem_wdata, w.addr, w.data);
                        end
                    end
                    if (first_wen < 0) first_wen = cyc;
                    last_wen = cyc; wen_cnt++; last_waddr = imem_addr;
                end
                if (cpu_enable) begin
                    if (first_en < 0) first_en = cyc;
                    last_en = cyc; en_cnt++;
                end
                if (dmem_ren && first_ren < 0) first_ren = cyc;
                if (prev_stall) begin
                    n_chk++;
                    if (m_valid !== 1'b1 || m_data !== prev_data) begin
                        n_fail++;
                        $display("FAIL stall_stable: valid=%0b data=%016h expected 1 %016h", m_valid, m_data, prev_data);
                    end
                end
                if (m_valid && m_ready) begin
                    n_chk++;
                    if (m_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL dump_extra: data=%016h with none expected", m_data);
                    end else if (m_data !== m_q[0]) begin
                        n_fail++;
                        $display("FAIL dump_word: data=%016h expected %016h", m_data, m_q[0]);
                        void'(m_q.pop_front());
                    end else begin
                        void'(m_q.pop_front());
                    end
                    acc++; last_acc = cyc;
                    if (acc == abort_after) abort_now = 1;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (done) begin finished = 1; done_cyc = cyc; end
            end
            cyc++;
        end
        s_valid = 1'b0; rst = 1'b0; start = 1'b0; m_ready = 1'b1;

        n_chk++;
        if (!finished) begin
            n_fail++;
            $display("FAIL seq_timeout: no completion after %0d cycles expected done", cyc);
        end
        if (finished && !aborted) begin
            n_chk++;
            if (imem_q.size() != 0 || m_q.size() != 0 || en_cnt != rcyc) begin
                n_fail++;
                $display("FAIL seq_totals: imem_left=%0d dump_left=%0d en=%0d expected 0 0 %0d",
                         imem_q.size(), m_q.size(), en_cnt, rcyc);
            end
            if (ed > 0) begin
                n_chk++;
                if (done_cyc != last_acc + 1) begin
                    n_fail++;
                    $display("FAIL done_timing: done at %0d expected %0d", done_cyc, last_acc + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; prog_len = 8'd3; run_cycles = 32'd2; dump_len = 8'd2;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (s_ready !== 1'b0 || imem_wen !== 1'b0 || imem_addr !== 64'd0 || imem_wdata !== 32'd0 ||
            cpu_enable !== 1'b0 || dmem_ren !== 1'b0 || dmem_addr !== 64'd0 || m_valid !== 1'b0 ||
            m_data !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%0b wen=%0b ia=%0h iw=%0h en=%0b ren=%0b da=%0h mv=%0b md=%0h busy=%0b done=%0b expected all 0",
                     s_ready, imem_wen, imem_addr, imem_wdata, cpu_enable, dmem_ren, dmem_addr, m_valid, m_data, busy, done);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_over_start: busy=%0b done=%0b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic_load();
        run_sequence(3, 2, 1, 0, 0, -1);
        n_chk++;
        if (wen_cnt != 3 || first_wen != 0 || last_wen != 2 || first_en != 3) begin
            n_fail++;
            $display("FAIL basic_load: writes=%0d first=%0d last=%0d run_start=%0d expected 3 0 2 3",
                     wen_cnt, first_wen, last_wen, first_en);
        end
    endtask

    task automatic test_run_cycles();
        run_sequence(1, 5, 2, 0, 0, -1);
        n_chk++;
        if (en_cnt != 5 || (last_en - first_en) != 4 || first_ren != last_en + 1) begin
            n_fail++;
            $display("FAIL run_cycles: en=%0d span=%0d first_ren=%0d expected 5 4 %0d",
                     en_cnt, last_en - first_en, first_ren, last_en + 1);
        end
    endtask

    task automatic test_dump_backpressure();
        run_sequence(0, 0, 4, 1, 0, -1);
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dump_bp_done: done=%0b busy=%0b expected 1 0", done, busy);
        end
    endtask

    task automatic test_zero_counts();
        run_sequence(0, 0, 2, 0, 0, -1);
        n_chk++;
        if (first_ren != 0 || wen_cnt != 0 || en_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_counts: first_ren=%0d wen=%0d en=%0d expected 0 0 0", first_ren, wen_cnt, en_cnt);
        end
    endtask

    task automatic test_start_ignored();
        run_sequence(2, 6, 3, 0, 1, -1);
        n_chk++;
        if (wen_cnt != 2 || en_cnt != 6 || first_ren != last_en + 1) begin
            n_fail++;
            $display("FAIL start_ignored: wen=%0d en=%0d first_ren=%0d expected 2 6 %0d",
                     wen_cnt, en_cnt, first_ren, last_en + 1);
        end
    endtask

    task automatic test_reset_mid_dump();
        run_sequence(1, 1, 4, 0, 0, 2);
        run_sequence(2, 3, 3, 0, 0, -1);
        n_chk++;
        if (wen_cnt != 2 || first_en != 2 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL after_abort: wen=%0d run_start=%0d done=%0b expected 2 2 1", wen_cnt, first_en, done);
        end
    endtask

    task automatic test_saturation();
        run_sequence(200, 1, 1, 0, 0, -1);
        n_chk++;
        if (wen_cnt != 128 || last_waddr !== 64'd508) begin
            n_fail++;
            $display("FAIL saturation: writes=%0d last_addr=%0d expected 128 508", wen_cnt, last_waddr);
        end
    endtask

    task automatic test_back_to_back();
        run_sequence(0, 0, 0, 0, 0, -1);
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL all_zero: done=%0b expected 1", done);
        end
        run_sequence(4, 2, 5, 1, 0, -1);
        n_chk++;
        if (wen_cnt != 4 || first_en != 4) begin
            n_fail++;
            $display("FAIL back_to_back: wen=%0d run_start=%0d expected 4 4", wen_cnt, first_en);
        end
    endtask

    initial begin
        for (int i = 0; i < DW; i++)
            dmem[i] = 64'hD0D0_0000_0000_0000 | (64'(i) << 32) | 64'(i * 7 + 1);
        test_reset();
        test_basic_load();
        test_run_cycles();
        test_dump_backpressure();
        test_zero_counts();
        test_start_ignored();
        test_reset_mid_dump();
        test_saturation();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
